// File: rtl/maze_pkg.sv
// Shared definitions for the maze move controller: directions, cell bit
// layout, grid size, controller states and the cell address helper.
package maze_pkg;

    localparam int GRID_DIM = 16;
    localparam int COORD_W  = 4;
    localparam int ADDR_W   = 8;
    localparam int CELL_W   = 9;

    // Highest legal row/column index.
    localparam logic [COORD_W-1:0] GRID_MAX = COORD_W'(GRID_DIM - 1);

    // Cell word layout.
    localparam int BIT_WALL_N  = 0;
    localparam int BIT_WALL_E  = 1;
    localparam int BIT_WALL_S  = 2;
    localparam int BIT_WALL_W  = 3;
    localparam int BIT_VISITED = 4;
    localparam int BIT_GOAL    = 5;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_CUR = 3'd1,
        S_CHECK  = 3'd2,
        S_RD_NEW = 3'd3,
        S_WR_NEW = 3'd4
    } state_t;

    // Maze memory is row-major: high nibble row, low nibble column.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] row,
                                                    input logic [COORD_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/maze_move_ctrl.sv
// Player move controller: reads the current cell's walls, validates the
// move against walls and grid edges, then marks the destination visited.
module maze_move_ctrl
    import maze_pkg::*;
#(
    parameter int START_ROW = 0,
    parameter int START_COL = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                move_valid,
    input  logic [1:0]          move_dir,
    output logic                move_ready,
    output logic                bram_en,
    output logic                bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [CELL_W-1:0]   bram_din,
    input  logic [CELL_W-1:0]   bram_dout,
    output logic [COORD_W-1:0]  player_row,
    output logic [COORD_W-1:0]  player_col,
    output logic                moved,
    output logic                blocked,
    output logic                at_goal
);

    localparam logic [COORD_W-1:0] START_ROW_L = COORD_W'(START_ROW);
    localparam logic [COORD_W-1:0] START_COL_L = COORD_W'(START_COL);

    state_t               state_reg, state_next;
    dir_t                 dir_reg;
    logic [COORD_W-1:0]   row_reg, col_reg;
    logic [COORD_W-1:0]   row_next, col_next;
    logic                 moved_reg, blocked_reg, at_goal_reg;
    logic                 block_hit;
    logic                 en_next, we_next;
    logic [ADDR_W-1:0]    addr_next;
    logic [CELL_W-1:0]    din_next;

    // Wall/edge test for the latched direction and candidate new position.
    always_comb begin
        block_hit = 1'b0;
        row_next  = row_reg;
        col_next  = col_reg;
        case (dir_reg)
            DIR_N: begin
                block_hit = bram_dout[BIT_WALL_N] || (row_reg == '0);
                row_next  = row_reg - 1'b1;
            end
            DIR_E: begin
                block_hit = bram_dout[BIT_WALL_E] || (col_reg == GRID_MAX);
                col_next  = col_reg + 1'b1;
            end
            DIR_S: begin
                block_hit = bram_dout[BIT_WALL_S] || (row_reg == GRID_MAX);
                row_next  = row_reg + 1'b1;
            end
            default: begin
                block_hit = bram_dout[BIT_WALL_W] || (col_reg == '0);
                col_next  = col_reg - 1'b1;
            end
        endcase
    end

    // Next-state and BRAM port decode.
    always_comb begin
        state_next = state_reg;
        en_next    = 1'b0;
        we_next    = 1'b0;
        addr_next  = '0;
        din_next   = '0;
        case (state_reg)
            S_IDLE: begin
                if (move_valid) state_next = S_RD_CUR;
            end
            S_RD_CUR: begin
                en_next    = 1'b1;
                addr_next  = cell_addr(row_reg, col_reg);
                state_next = S_CHECK;
            end
            S_CHECK: begin
                state_next = block_hit ? S_IDLE : S_RD_NEW;
            end
            S_RD_NEW: begin
                en_next    = 1'b1;
                addr_next  = cell_addr(row_reg, col_reg);
                state_next = S_WR_NEW;
            end
            S_WR_NEW: begin
                en_next    = 1'b1;
                we_next    = 1'b1;
                addr_next  = cell_addr(row_reg, col_reg);
                din_next   = bram_dout | (CELL_W'(1) << BIT_VISITED);
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, position, latched direction and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            dir_reg     <= DIR_N;
            row_reg     <= START_ROW_L;
            col_reg     <= START_COL_L;
            moved_reg   <= 1'b0;
            blocked_reg <= 1'b0;
            at_goal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            moved_reg   <= 1'b0;
            blocked_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (move_valid) dir_reg <= dir_t'(move_dir);
                end
                S_CHECK: begin
                    if (block_hit) begin
                        blocked_reg <= 1'b1;
                    end else begin
                        row_reg <= row_next;
                        col_reg <= col_next;
                    end
                end
                S_WR_NEW: begin
                    moved_reg   <= 1'b1;
                    at_goal_reg <= bram_dout[BIT_GOAL];
                end
                default: ;
            endcase
        end
    end

    // Port is silenced while reset is high so an aborted move never writes.
    assign bram_en    = en_next & ~reset;
    assign bram_we    = we_next & ~reset;
    assign bram_addr  = addr_next;
    assign bram_din   = din_next;
    assign move_ready = (state_reg == S_IDLE);
    assign player_row = row_reg;
    assign player_col = col_reg;
    assign moved      = moved_reg;
    assign blocked    = blocked_reg;
    assign at_goal    = at_goal_reg;

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Directed bench for maze_move_ctrl with a behavioural maze BRAM.
module tb_maze_move_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;
    logic       bram_en, bram_we;
    logic [7:0] bram_addr;
    logic [8:0] bram_din;
    logic [8:0] bram_dout = '0;
    logic [3:0] player_row, player_col;
    logic       moved, blocked, at_goal;

    logic [8:0] mem [0:255];
    logic       poke_en = 1'b0;
    logic [7:0] poke_addr = '0;
    logic [8:0] poke_data = '0;

    logic [7:0] rd_q [$];
    logic [7:0] wr_addr_q [$];
    logic [8:0] wr_data_q [$];

    int n_vec = 0;
    int n_err = 0;
    int lat;

    maze_move_ctrl #(.START_ROW(0), .START_COL(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout),
        .player_row (player_row),
        .player_col (player_col),
        .moved      (moved),
        .blocked    (blocked),
        .at_goal    (at_goal)
    );

    always #5 clk = ~clk;

    // Maze memory: registered read-first port plus a bench preload path.
    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            bram_dout <= mem[bram_addr];
        end
    end

    // Log every BRAM access presented in each cycle.
    always @(negedge clk) begin
        if (bram_en && !bram_we) rd_q.push_back(bram_addr);
        if (bram_en && bram_we) begin
            wr_addr_q.push_back(bram_addr);
            wr_data_q.push_back(bram_din);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [8:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        step();
        poke_en   = 1'b0;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Issue one move and wait (bounded) for moved or blocked.
    task automatic do_move(input logic [1:0] dir, output int latency);
        chk("ready_before_move", move_ready, 1);
        move_valid = 1'b1;
        move_dir   = dir;
        step();
        move_valid = 1'b0;
        latency = 0;
        while (!(moved || blocked) && latency < 12) begin
            step();
            latency++;
        end
        $display("move dir=%0d latency=%0d moved=%0b blocked=%0b pos=(%0d,%0d) at_goal=%0b",
                 dir, latency, moved, blocked, player_row, player_col, at_goal);
    endtask

    initial begin
        int acc, mv, ov;
        reset      = 1'b1;
        move_valid = 1'b0;
        move_dir   = 2'd0;
        // Clear the whole maze while the DUT is held in reset.
        for (int a = 0; a < 256; a++) poke(8'(a), 9'h000);
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_ready",   move_ready, 1);
        chk("rst_moved",   moved, 0);
        chk("rst_blocked", blocked, 0);
        chk("rst_at_goal", at_goal, 0);
        chk("rst_en",      bram_en, 0);
        chk("rst_we",      bram_we, 0);
        chk("rst_addr",    bram_addr, 0);
        chk("rst_din",     bram_din, 0);
        chk("rst_row",     player_row, 0);
        chk("rst_col",     player_col, 0);

        // Open move east from (0,0)
        clear_logs();
        do_move(2'd1, lat);
        chk("e_lat",      lat, 4);
        chk("e_moved",    moved, 1);
        chk("e_blocked",  blocked, 0);
        chk("e_rd_cnt",   rd_q.size(), 2);
        if (rd_q.size() == 2) begin
            chk("e_rd_cur", rd_q[0], 8'h00);
            chk("e_rd_new", rd_q[1], 8'h01);
        end
        chk("e_wr_cnt",   wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            chk("e_wr_addr", wr_addr_q[0], 8'h01);
            chk("e_wr_data", wr_data_q[0], 9'h010);
        end
        chk("e_row",      player_row, 0);
        chk("e_col",      player_col, 1);
        step();
        chk("e_pulse_end", moved, 0);

        // East wall blocks the move
        do_reset();
        poke(8'h00, 9'h002);
        clear_logs();
        do_move(2'd1, lat);
        chk("wall_lat",     lat, 2);
        chk("wall_blocked", blocked, 1);
        chk("wall_moved",   moved, 0);
        chk("wall_rd_cnt",  rd_q.size(), 1);
        chk("wall_wr_cnt",  wr_addr_q.size(), 0);
        chk("wall_row",     player_row, 0);
        chk("wall_col",     player_col, 0);

        // North off-grid with clear wall bit
        poke(8'h00, 9'h000);
        clear_logs();
        do_move(2'd0, lat);
        chk("bnd_lat",     lat, 2);
        chk("bnd_blocked", blocked, 1);
        chk("bnd_rd_cnt",  rd_q.size(), 1);
        chk("bnd_wr_cnt",  wr_addr_q.size(), 0);
        chk("bnd_row",     player_row, 0);

        // Goal cell with reserved bits set
        poke(8'h01, 9'h1E0);
        clear_logs();
        do_move(2'd1, lat);
        chk("goal_moved", moved, 1);
        chk("goal_wr_cnt", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            chk("goal_wr_addr", wr_addr_q[0], 8'h01);
            chk("goal_wr_data", wr_data_q[0], 9'h1F0);
        end
        chk("goal_at_goal", at_goal, 1);
        chk("goal_col", player_col, 1);

        // Move south off the goal cell
        clear_logs();
        do_move(2'd2, lat);
        chk("s_moved",   moved, 1);
        chk("s_at_goal", at_goal, 0);
        chk("s_row",     player_row, 1);
        chk("s_col",     player_col, 1);
        if (wr_addr_q.size() == 1) chk("s_wr_addr", wr_addr_q[0], 8'h11);
        else chk("s_wr_cnt", wr_addr_q.size(), 1);

        // West wall at (1,1)
        poke(8'h11, 9'h018);
        clear_logs();
        do_move(2'd3, lat);
        chk("w_blocked", blocked, 1);
        chk("w_moved",   moved, 0);
        chk("w_col",     player_col, 1);
        chk("w_wr_cnt",  wr_addr_q.size(), 0);

        // Reset during RD_NEW aborts the move
        do_reset();
        clear_logs();
        move_valid = 1'b1;
        move_dir   = 2'd1;
        step();
        move_valid = 1'b0;
        step();
        step();
        chk("abort_rd_new_en",   bram_en, 1);
        chk("abort_rd_new_addr", bram_addr, 8'h01);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_ready", move_ready, 1);
        chk("abort_row",   player_row, 0);
        chk("abort_col",   player_col, 0);
        chk("abort_moved", moved, 0);
        for (int i = 0; i < 4; i++) step();
        chk("abort_wr_cnt", wr_addr_q.size(), 0);
        chk("abort_at_goal", at_goal, 0);
        $display("abort pos=(%0d,%0d) writes=%0d", player_row, player_col, wr_addr_q.size());

        // move_valid held high: one accept per completed move
        clear_logs();
        acc = 0; mv = 0; ov = 0;
        move_valid = 1'b1;
        move_dir   = 2'd2;
        for (int i = 0; i < 20; i++) begin
            if (move_valid && move_ready) acc++;
            if (moved) mv++;
            if (moved && blocked) ov++;
            step();
        end
        move_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (moved) mv++;
            if (moved && blocked) ov++;
            step();
        end
        $display("held accepts=%0d moves=%0d overlap=%0d row=%0d", acc, mv, ov, player_row);
        chk("held_accepts", acc, 4);
        chk("held_moves",   mv, 4);
        chk("held_overlap", ov, 0);
        chk("held_row",     player_row, 4);
        chk("held_writes",  wr_addr_q.size(), 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/maze_move_ctrl.md
MAZE_MOVE_CTRL -- requirements
Module: maze_move_ctrl

Interface
REQ-001 Parameter START_ROW, default 0, player start row (0..15).
REQ-002 Parameter START_COL, default 0, player start column (0..15).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 move_valid  input  1  move request present.
REQ-006 move_dir  input  2  direction: 0=N, 1=E, 2=S, 3=W.
REQ-007 move_ready  output  1  high only in IDLE; request accepted on a clock edge where move_valid and move_ready are both high.
REQ-008 bram_en  output  1  maze BRAM port enable.
REQ-009 bram_we  output  1  maze BRAM write enable.
REQ-010 bram_addr  output  8  cell address = {row[3:0], col[3:0]}.
REQ-011 bram_din  output  9  write data.
REQ-012 bram_dout  input  9  read data; registered, valid the cycle after the address is presented with bram_en high.
REQ-013 player_row / player_col  output  4 each  registered current position.
REQ-014 moved  output  1  one-cycle pulse: move completed.
REQ-015 blocked  output  1  one-cycle pulse: move rejected.
REQ-016 at_goal  output  1  level: current cell has the goal bit set.

Function
REQ-017 Cell format: bit0 N wall, bit1 E wall, bit2 S wall, bit3 W wall, bit4 visited, bit5 goal, bits8:6 reserved; reserved bits are preserved on write.
REQ-018 FSM states: IDLE, RD_CUR, CHECK, RD_NEW, WR_NEW.
REQ-019 IDLE: on accept, latch move_dir; go to RD_CUR.
REQ-020 RD_CUR: bram_en=1, bram_we=0, bram_addr=current cell; go to CHECK.
REQ-021 CHECK: if the wall bit for the latched direction is set, or the move leaves the grid (row 0 N, col 15 E, row 15 S, col 0 W), pulse blocked and return to IDLE; position is unchanged.
REQ-022 CHECK: otherwise, update position (row±1 / col±1, no wrap) and go to RD_NEW.
REQ-023 RD_NEW: bram_en=1, bram_we=0, bram_addr=new cell; go to WR_NEW.
REQ-024 WR_NEW: bram_en=1, bram_we=1, bram_din = bram_dout with bit4 set; at_goal := bram_dout bit5; pulse moved; return to IDLE.
REQ-025 Latency: blocked asserts 2 cycles after accept; moved asserts 4 cycles after accept; next accept possible on the cycle the pulse is high.
REQ-026 The grid boundary overrides the wall bits: an off-grid move is blocked even if the wall bit is clear.
REQ-027 move_valid while busy is ignored; no queuing.
REQ-028 bram_en=0 and bram_we=0 in IDLE and CHECK; at most one BRAM write per accepted move.
REQ-029 moved and blocked are never high together.

Reset
REQ-030 Reset: state=IDLE, player_row=START_ROW, player_col=START_COL, latched dir=0, moved=0, blocked=0, at_goal=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0.
REQ-031 Reset asserted mid-move aborts the move in the same cycle; no BRAM write is issued on that edge or after it; position returns to start.
REQ-032 Reset has priority over a simultaneous move_valid.

Structure
REQ-033 Shared package maze_pkg holds the direction encodings, cell bit indices, GRID_DIM=16, and the state enum.
REQ-034 The block is a single module with no sub-modules; the address concatenation is a package function.

Verification
REQ-035 Start (0,0), cell 0x00 = 9'h000, move E -> RD_CUR addr 0x00, RD_NEW addr 0x01, write 0x01 <= old|0x010, moved at accept+4, col=1.
REQ-036 Cell 0x00 = 9'h002 (E wall), move E -> blocked at accept+2, no write, position (0,0).
REQ-037 At (0,0), cell clear, move N -> blocked (boundary), no BRAM activity after RD_CUR.
REQ-038 Target cell 9'h1E0 (goal + reserved bits) -> write 9'h1F0, at_goal=1 after moved.
REQ-039 Reset asserted during RD_NEW -> no write observed, state IDLE, position (START_ROW, START_COL), move_ready=1 the next cycle.
REQ-040 move_valid held high continuously -> exactly one accept per completed move; moved/blocked never overlap.
